// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bundle: decoded operand/destination info in, stall/flush and
// registered forwarding selects out.
interface hazard_scoreboard_if #(
  parameter int RW = 5,
  parameter int LW = 3,
  parameter int SW = 3
);
  logic          id_valid;
  logic [RW-1:0] id_rs1;
  logic          id_use_rs1;
  logic [RW-1:0] id_rs2;
  logic          id_use_rs2;
  logic          id_rs2_late;
  logic          id_wen;
  logic [RW-1:0] id_rd;
  logic [LW-1:0] id_lat;
  logic          ex_redirect;
  logic          stall;
  logic          flush;
  logic [SW-1:0] fw_sel1_ex;
  logic [SW-1:0] fw_sel2_ex;
  logic [SW-1:0] fw_sel2_mem;

  modport master (
    output id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2, id_rs2_late,
           id_wen, id_rd, id_lat, ex_redirect,
    input  stall, flush, fw_sel1_ex, fw_sel2_ex, fw_sel2_mem
  );

  modport slave (
    input  id_valid, id_rs1, id_use_rs1, id_rs2, id_use_rs2, id_rs2_late,
           id_wen, id_rd, id_lat, ex_redirect,
    output stall, flush, fw_sel1_ex, fw_sel2_ex, fw_sel2_mem
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Latency-aware hazard scoreboard: tracks in-flight destinations for DEPTH
// stages after ID, raises stalls and registers operand forwarding selects.
module hazard_scoreboard #(
  parameter int RW      = 5,
  parameter int DEPTH   = 3,
  parameter int MAX_LAT = 4,
  parameter int LW      = $clog2(MAX_LAT + 1),
  parameter int SW      = $clog2(DEPTH + 2)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  logic [DEPTH:1] vld_q, vld_d;
  logic [RW-1:0]  rd_q  [1:DEPTH];
  logic [RW-1:0]  rd_d  [1:DEPTH];
  logic [LW-1:0]  lat_q [1:DEPTH];
  logic [LW-1:0]  lat_d [1:DEPTH];

  logic [SW-1:0] sel1_q, sel1_d;
  logic [SW-1:0] sel2_q, sel2_d;
  logic [SW-1:0] late_ex_q, late_ex_d;
  logic [SW-1:0] late_mem_q;

  logic          stall, bubble;
  logic          hit1, hit2, used1, used2, haz1, haz2;
  int            k1, k2;
  logic [LW-1:0] lat1, lat2;

  function automatic logic [LW-1:0] lat_norm(input logic [LW-1:0] l);
    return (l == '0) ? LW'(1) : l;
  endfunction

  function automatic logic [LW-1:0] lat_dec(input logic [LW-1:0] l);
    return (l == '0) ? '0 : l - LW'(1);
  endfunction

  // Youngest-match lookup: scan oldest to youngest so the smallest k lands last.
  always_comb begin
    hit1 = 1'b0; k1 = 0; lat1 = '0;
    hit2 = 1'b0; k2 = 0; lat2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (vld_q[k] && rd_q[k] == bus.id_rs1) begin
        hit1 = 1'b1; k1 = k; lat1 = lat_q[k];
      end
      if (vld_q[k] && rd_q[k] == bus.id_rs2) begin
        hit2 = 1'b1; k2 = k; lat2 = lat_q[k];
      end
    end
  end

  always_comb begin
    used1  = bus.id_use_rs1 && (bus.id_rs1 != '0) && hit1;
    used2  = bus.id_use_rs2 && (bus.id_rs2 != '0) && hit2;
    haz1   = used1 && (lat1 > LW'(1));
    sel1_d = (used1 && k1 != DEPTH) ? SW'(k1 + 1) : '0;
    haz2      = 1'b0;
    sel2_d    = '0;
    late_ex_d = '0;
    // Store data is consumed a stage later, so one extra cycle of latency is tolerated.
    if (bus.id_rs2_late) begin
      haz2      = used2 && (lat2 > LW'(2));
      late_ex_d = (used2 && (k2 + 2 <= DEPTH)) ? SW'(k2 + 2) : '0;
    end else begin
      haz2   = used2 && (lat2 > LW'(1));
      sel2_d = (used2 && k2 != DEPTH) ? SW'(k2 + 1) : '0;
    end
    stall  = bus.id_valid && (haz1 || haz2) && !bus.ex_redirect;
    bubble = stall || bus.ex_redirect || !bus.id_valid;
  end

  always_comb begin
    vld_d[1] = bus.id_valid && bus.id_wen && (bus.id_rd != '0) && !stall && !bus.ex_redirect;
    rd_d[1]  = bus.id_rd;
    lat_d[1] = lat_norm(bus.id_lat);
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      lat_d[k] = lat_dec(lat_q[k-1]);
    end
  end

  // ID -> EX boundary: scoreboard shift and EX-side selects; EX -> MEM for the late select.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      sel1_q     <= '0;
      sel2_q     <= '0;
      late_ex_q  <= '0;
      late_mem_q <= '0;
    end else begin
      vld_q      <= vld_d;
      sel1_q     <= bubble ? '0 : sel1_d;
      sel2_q     <= bubble ? '0 : sel2_d;
      late_ex_q  <= bubble ? '0 : late_ex_d;
      late_mem_q <= late_ex_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k <= DEPTH; k++) begin
      rd_q[k]  <= rd_d[k];
      lat_q[k] <= lat_d[k];
    end
  end

  assign bus.stall       = stall;
  assign bus.flush       = bus.ex_redirect;
  assign bus.fw_sel1_ex  = sel1_q;
  assign bus.fw_sel2_ex  = sel2_q;
  assign bus.fw_sel2_mem = late_mem_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: expected outputs are queued with a due cycle as stimulus is
// driven and compared when that cycle arrives (DEPTH=3 and DEPTH=5 instances).
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.RW(5), .LW(3), .SW(3)) b3 ();
  hazard_scoreboard_if #(.RW(5), .LW(3), .SW(3)) b5 ();

  hazard_scoreboard #(.RW(5), .DEPTH(3), .MAX_LAT(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  hazard_scoreboard #(.RW(5), .DEPTH(5), .MAX_LAT(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  // sig ids: 0 stall, 1 flush, 2 sel1_ex, 3 sel2_ex, 4 sel2_mem; +10 for the DEPTH=5 instance
  localparam int ST = 0, FL = 1, S1 = 2, S2 = 3, SM = 4, D5 = 10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int obs(input int sig);
    case (sig)
      ST:      return int'(b3.stall);
      FL:      return int'(b3.flush);
      S1:      return int'(b3.fw_sel1_ex);
      S2:      return int'(b3.fw_sel2_ex);
      SM:      return int'(b3.fw_sel2_mem);
      D5 + ST: return int'(b5.stall);
      D5 + FL: return int'(b5.flush);
      D5 + S1: return int'(b5.fw_sel1_ex);
      D5 + S2: return int'(b5.fw_sel2_ex);
      D5 + SM: return int'(b5.fw_sel2_mem);
      default: return -1;
    endcase
  endfunction

  task automatic expect_at(input int sig, input int off, input int val, input string tag);
    exp_t e;
    e.cyc = cyc + off;
    e.sig = sig;
    e.val = val;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        chk(exp_q[i].tag, obs(exp_q[i].sig), exp_q[i].val);
        exp_q.delete(i);
      end
    end
  end

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit late, input bit wen, input int rd, input int lat, input bit redir);
    b3.id_valid = v;  b3.id_rs1 = 5'(rs1); b3.id_use_rs1 = u1;
    b3.id_rs2 = 5'(rs2); b3.id_use_rs2 = u2; b3.id_rs2_late = late;
    b3.id_wen = wen;  b3.id_rd = 5'(rd); b3.id_lat = 3'(lat); b3.ex_redirect = redir;
    b5.id_valid = v;  b5.id_rs1 = 5'(rs1); b5.id_use_rs1 = u1;
    b5.id_rs2 = 5'(rs2); b5.id_use_rs2 = u2; b5.id_rs2_late = late;
    b5.id_wen = wen;  b5.id_rd = 5'(rd); b5.id_lat = 3'(lat); b5.ex_redirect = redir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prod(input int rd, input int lat);
    drive(1, 0, 0, 0, 0, 0, 1, rd, lat, 0);
  endtask

  task automatic cons(input int rs1, input bit u1, input int rs2, input bit u2, input bit late);
    drive(1, rs1, u1, rs2, u2, late, 0, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    expect_at(ST, 0, 0, "rst_stall");
    expect_at(FL, 0, 0, "rst_flush");
    expect_at(S1, 0, 0, "rst_sel1");
    expect_at(S2, 0, 0, "rst_sel2");
    expect_at(SM, 0, 0, "rst_sel2mem");
    tick();
    rst_n = 1'b1;
    drain(2);

    // ALU producer then dependent consumer: forward from stage 2
    prod(5, 1); expect_at(ST, 0, 0, "alu_prod_stall"); tick();
    cons(5, 1, 7, 1, 0);
    expect_at(ST, 0, 0, "alu_use_stall");
    expect_at(S1, 1, 2, "alu_use_sel1");
    expect_at(S2, 1, 0, "alu_use_sel2_nomatch");
    tick(); drain(5);

    // producer two and three stages ahead
    prod(5, 1); tick(); drain(1);
    cons(0, 0, 5, 1, 0); expect_at(S2, 1, 3, "k2_sel2"); tick(); drain(5);
    prod(5, 1); tick(); drain(2);
    cons(5, 1, 0, 0, 0); expect_at(ST, 0, 0, "k3_stall"); expect_at(S1, 1, 0, "k3_sel1_regfile");
    tick(); drain(5);

    // load-use: exactly one stall, bubble carries no select
    prod(5, 2); tick();
    cons(5, 1, 0, 1, 0);
    expect_at(ST, 0, 1, "lu_stall");
    expect_at(FL, 0, 0, "lu_flush");
    expect_at(S1, 1, 0, "lu_bubble_sel1");
    tick();
    expect_at(ST, 0, 0, "lu_release");
    expect_at(S1, 1, 3, "lu_sel1");
    tick(); drain(5);

    // load then store data: late forwarding, no stall
    prod(5, 2); tick();
    cons(8, 1, 5, 1, 1);
    expect_at(ST, 0, 0, "st_stall");
    expect_at(S2, 1, 0, "st_sel2_ex");
    expect_at(S1, 1, 0, "st_sel1");
    expect_at(SM, 1, 0, "st_sel2mem_early");
    expect_at(SM, 2, 3, "st_sel2mem");
    tick(); drain(5);

    // load then store using the loaded value as address
    prod(5, 2); tick();
    cons(5, 1, 8, 1, 1); expect_at(ST, 0, 1, "sta_stall"); tick();
    expect_at(ST, 0, 0, "sta_release");
    expect_at(S1, 1, 3, "sta_sel1");
    expect_at(SM, 2, 0, "sta_sel2mem");
    tick(); drain(5);

    // late select past the last stage reads the regfile
    prod(5, 2); tick(); drain(1);
    cons(0, 0, 5, 1, 1); expect_at(SM, 2, 0, "late_deep_sel2mem"); tick(); drain(5);

    // lat=3 producer with late consumer: one stall, then MEM select k+2
    prod(5, 3); tick();
    cons(0, 0, 5, 1, 1);
    expect_at(ST, 0, 1, "late3_stall");
    expect_at(D5 + ST, 0, 1, "late3_stall_d5");
    tick();
    expect_at(ST, 0, 0, "late3_release");
    expect_at(SM, 2, 0, "late3_sel2mem_d3");
    expect_at(D5 + SM, 2, 4, "late3_sel2mem_d5");
    tick(); drain(5);

    // DEPTH=5: lat=4 producer gives three stall cycles, then select 5
    prod(9, 4); tick();
    cons(9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      expect_at(D5 + ST, 0, 1, $sformatf("lat4_stall%0d", i));
      tick();
    end
    expect_at(D5 + ST, 0, 0, "lat4_release");
    expect_at(D5 + S1, 1, 5, "lat4_sel1");
    tick(); drain(5);

    // id_lat=0 behaves as ALU latency
    prod(5, 0); tick();
    cons(5, 1, 0, 0, 0); expect_at(ST, 0, 0, "lat0_stall"); expect_at(S1, 1, 2, "lat0_sel1");
    tick(); drain(5);

    // two writers of x5: youngest wins; x0 writer never tracked
    prod(5, 1); tick(); prod(5, 1); tick();
    cons(5, 1, 0, 0, 0); expect_at(S1, 1, 2, "young_sel1"); tick(); drain(5);
    prod(0, 3); expect_at(ST, 0, 0, "x0_prod_stall"); tick();
    cons(0, 1, 0, 1, 0);
    expect_at(ST, 0, 0, "x0_use_stall");
    expect_at(S1, 1, 0, "x0_sel1");
    expect_at(S2, 1, 0, "x0_sel2");
    tick(); drain(5);

    // load-use coinciding with redirect: flush wins, the killed op leaves a bubble
    prod(5, 2); tick();
    drive(1, 5, 1, 0, 0, 0, 1, 6, 1, 1);
    expect_at(ST, 0, 0, "redir_stall");
    expect_at(FL, 0, 1, "redir_flush");
    expect_at(S1, 1, 0, "redir_sel1");
    tick();
    cons(6, 1, 5, 1, 0);
    expect_at(ST, 0, 0, "redir_next_stall");
    expect_at(FL, 0, 0, "redir_next_flush");
    expect_at(S1, 1, 0, "redir_bubble_sel1");
    expect_at(S2, 1, 3, "redir_older_sel2");
    tick(); drain(5);

    // reset during a stall
    prod(5, 2); tick();
    cons(5, 1, 0, 0, 0); rst_n = 1'b0;
    expect_at(ST, 0, 1, "prerst_stall");
    tick();
    rst_n = 1'b1;
    expect_at(ST, 0, 0, "postrst_stall");
    expect_at(S1, 0, 0, "postrst_sel1");
    expect_at(S2, 0, 0, "postrst_sel2");
    expect_at(SM, 0, 0, "postrst_sel2mem");
    expect_at(S1, 1, 0, "postrst_issue_sel1");
    tick(); drain(5);

    chk("unserved", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed 5-stage load-use/forwarding detector. It tracks in-flight destination registers in a DEPTH-entry shift scoreboard, and each entry carries a per-instruction result latency. From these it generates stalls for any producer latency (ALU, load, multi-cycle ops) and registered forwarding selects for EX-stage operands and late (MEM-stage) store data. It sits beside the ID stage, and its outputs drive the IF/ID hold, the ID/EX bubble and the operand muxes.

Parameters:
RW, 5, register index width
DEPTH, 3, pipeline stages after ID that can hold a producer (EX=1 … WB=DEPTH)
MAX_LAT, 4, largest allowed id_lat value
LW, $clog2(MAX_LAT+1), latency field width
SW, $clog2(DEPTH+2), forwarding select width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  RW  source 1 index
id_use_rs1  in  1  instruction reads rs1 in EX
id_rs2  in  RW  source 2 index
id_use_rs2  in  1  instruction reads rs2
id_rs2_late  in  1  rs2 consumed in MEM (store data), not EX
id_wen  in  1  instruction writes id_rd
id_rd  in  RW  destination index
id_lat  in  LW  cycles after EX entry until result is forwardable (ALU=1, load=2)
ex_redirect  in  1  taken branch/jump resolved in EX this cycle
stall  out  1  hold PC and IF/ID, insert bubble into EX
flush  out  1  kill IF/ID contents (=ex_redirect)
fw_sel1_ex  out  SW  registered rs1 source for EX: 0=regfile, k=output of stage k-1 register
fw_sel2_ex  out  SW  registered rs2 source for EX
fw_sel2_mem  out  SW  registered rs2 source for MEM (late operand)

Behaviour:
- Clock is clk. Reset is synchronous and active-low on rst_n.
- Scoreboard S[1..DEPTH]: each entry holds {valid, rd, lat}. S[k] is the instruction k cycles past ID.
- Every cycle, regardless of stall: S[k+1] <= S[k] with lat <= (lat==0 ? 0 : lat-1). S[DEPTH] retires; the regfile is write-before-read.
- S[1] loads:
  - {1, id_rd, id_lat} when id_valid & id_wen & id_rd!=0 & !stall & !ex_redirect.
  - Otherwise it loads invalid, which is a bubble.
- Per used source rs (rs!=0): take the smallest k with S[k].valid & S[k].rd==rs. Youngest match wins; older matches are ignored.
- EX operand:
  - Hazard if S[k].lat>1.
  - Otherwise the select is k+1, or 0 if k==DEPTH.
  - With no match, select is 0.
- Late operand (id_rs2_late):
  - Hazard if S[k].lat>2.
  - Otherwise the select for MEM is k+2, or 0 if k+2>DEPTH.
  - fw_sel2_ex is 0 in this case.
- stall = id_valid & (hazard1 | hazard2) & !ex_redirect. Redirect overrides stall.
- Forwarding select registers:
  - fw_sel1_ex and fw_sel2_ex update each cycle from the ID decision.
  - They take 0 when stall, ex_redirect or !id_valid, because the bubble needs no forwarding.
- fw_sel2_mem is a two-stage register:
  - A late select is captured at ID→EX and presented one cycle later, when the instruction is in MEM.
  - Both stages clear on the bubble conditions above.
  - The EX-stage copy clears on ex_redirect.
- Selects are computed for the cycle after the decision. The "k+1" / "k+2" offsets account for the producer advancing one stage.
- id_lat==0 is treated as 1. Values >MAX_LAT are undefined.
- Reset (rst_n=0 at posedge):
  - All S entries invalid.
  - fw_sel* = 0.
  - stall and flush are combinational and read 0 when the scoreboard is empty and ex_redirect=0.
- Reset mid-stall: the next cycle has an empty scoreboard and stall=0.
- Simultaneous stall condition and ex_redirect: flush=1, stall=0, S[1] bubble, fw_sel*_ex=0.
- A stalled instruction re-evaluates each cycle as producers age. stall deasserts in the first cycle all hazards clear.
- No combinational path from fw_sel* to any input.

Test Plan:
- DEPTH=3. Issue `add x5` (lat=1), then `sub x6,x5,x7`.
  -> stall=0. Next cycle fw_sel1_ex=2.
- `lw x5` (lat=2), then `add x6,x5,x0`.
  -> stall=1 for exactly 1 cycle, then the add issues with fw_sel1_ex=3.
- `lw x5`, then `sw x5,0(x8)` (rs2_late=1).
  -> stall=0. fw_sel2_ex=0, and fw_sel2_mem=3 two cycles after issue. Repeat with rs1=x5 -> 1-cycle stall.
- Producer lat=4 into x9, then a consumer.
  -> 3 stall cycles, then fw_sel=k+1 with k=4>DEPTH... Use DEPTH=5 for this case: stall 3 cycles, then fw_sel1_ex=5.
- `add x5` twice in a row, then a consumer of x5.
  -> select points to the younger producer (2), not 3. A producer with rd=x0 never stalls and never forwards.
- Load-use stall with ex_redirect=1 in the same cycle.
  -> stall=0, flush=1, S[1] bubble. rst_n=0 during a stall -> stall=0 and all fw_sel=0 the next cycle.
